// File: rtl/frame_mem_slave.sv
// frame_mem_slave: single-port frame buffer with separate write and read
// request channels.
// A round-robin arbiter grants one request at a time, and a small FSM adds a
// programmable number of wait cycles to each access. Accesses that are out of
// range or misaligned still complete on schedule, but they raise a sticky
// error flag.
module frame_mem_slave #(
    parameter int frameSize  = 640,
    parameter int WRITE_WAIT = 1,
    parameter int READ_WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] write_addr,
    input  logic [31:0] iData,
    input  logic        write,
    output logic        write_waitrequest,
    input  logic [31:0] read_addr,
    input  logic        read,
    output logic [31:0] oData,
    output logic        read_waitrequest,
    output logic [31:0] wr_count,
    output logic [31:0] rd_count,
    output logic        addr_err
);

    localparam int          AW          = (frameSize > 1) ? $clog2(frameSize) : 1;
    localparam logic [29:0] FRAME_WORDS = 30'(frameSize);
    localparam logic [3:0]  WR_LIMIT    = 4'(WRITE_WAIT);
    localparam logic [3:0]  RD_LIMIT    = 4'(READ_WAIT);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_WAIT = 3'd1,
        WR_DONE = 3'd2,
        RD_WAIT = 3'd3,
        RD_DONE = 3'd4
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg;
    logic [31:0]     addr_reg;
    logic            last_grant_reg;   // 1: last grant was a write, 0: a read
    logic            grant_wr;
    logic            grant_rd;
    logic            in_range;
    logic            ram_we;
    logic [AW-1:0]   ram_idx;
    logic [31:0]     ram_q;
    logic [31:0]     mem [0:frameSize-1];

    // When both requests are pending, serve the type that was not granted last.
    assign grant_wr = write && (!read || !last_grant_reg);
    assign grant_rd = read && !grant_wr;

    // The latched address decides validity for the whole access.
    assign in_range = (addr_reg[1:0] == 2'b00) && (addr_reg[31:2] < FRAME_WORDS);
    assign ram_idx  = addr_reg[AW+1:2];
    assign ram_we   = (state_reg == WR_DONE) && in_range;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Next-state logic. A dropped request aborts the access before completion.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant_wr)
                    state_next = WR_WAIT;
                else if (grant_rd)
                    state_next = RD_WAIT;
            end
            WR_WAIT: begin
                if (!write)
                    state_next = IDLE;
                else if (cnt_reg == WR_LIMIT)
                    state_next = WR_DONE;
            end
            RD_WAIT: begin
                if (!read)
                    state_next = IDLE;
                else if (cnt_reg == RD_LIMIT)
                    state_next = RD_DONE;
            end
            WR_DONE: state_next = IDLE;
            RD_DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic. Each waitrequest drops only in its own completion state.
    always_comb begin
        write_waitrequest = 1'b1;
        read_waitrequest  = 1'b1;
        if (state_reg == WR_DONE)
            write_waitrequest = 1'b0;
        if (state_reg == RD_DONE)
            read_waitrequest = 1'b0;
    end

    // Datapath: address/grant latch, wait counter, read data and statistics.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg        <= 4'd0;
            addr_reg       <= 32'd0;
            last_grant_reg <= 1'b0;
            oData          <= 32'd0;
            wr_count       <= 32'd0;
            rd_count       <= 32'd0;
            addr_err       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= 4'd0;
                    if (grant_wr) begin
                        addr_reg       <= write_addr;
                        last_grant_reg <= 1'b1;
                    end else if (grant_rd) begin
                        addr_reg       <= read_addr;
                        last_grant_reg <= 1'b0;
                    end
                end
                WR_WAIT: cnt_reg <= cnt_reg + 4'd1;
                RD_WAIT: begin
                    cnt_reg <= cnt_reg + 4'd1;
                    // ram_q lags the address by one cycle; READ_WAIT >= 1
                    // guarantees the final load here sees the right word.
                    oData   <= in_range ? ram_q : 32'd0;
                end
                WR_DONE: begin
                    if (in_range)
                        wr_count <= wr_count + 32'd1;
                    else
                        addr_err <= 1'b1;
                end
                RD_DONE: begin
                    rd_count <= rd_count + 32'd1;
                    if (!in_range)
                        addr_err <= 1'b1;
                end
                default: cnt_reg <= 4'd0;
            endcase
        end
    end

    // Single-port storage with a registered read. There is no reset, so the
    // contents survive a reset.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[ram_idx] <= iData;
        ram_q <= mem[ram_idx];
    end

endmodule

// File: tb/tb_frame_mem_slave.sv
// Testbench for frame_mem_slave.
// Stimulus tasks drive requests and push the expected completions into a
// queue. A separate monitor pops and checks each completion when a
// waitrequest drops. The reference model is a word map with counters.
module tb_frame_mem_slave;

    localparam int FS = 640;
    localparam int WW = 1;
    localparam int RW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] write_addr = 32'd0;
    logic [31:0] iData = 32'd0;
    logic        write = 1'b0;
    logic        write_waitrequest;
    logic [31:0] read_addr = 32'd0;
    logic        read = 1'b0;
    logic [31:0] oData;
    logic        read_waitrequest;
    logic [31:0] wr_count;
    logic [31:0] rd_count;
    logic        addr_err;

    frame_mem_slave #(.frameSize(FS), .WRITE_WAIT(WW), .READ_WAIT(RW)) dut (
        .clk              (clk),
        .reset            (rst),
        .write_addr       (write_addr),
        .iData            (iData),
        .write            (write),
        .write_waitrequest(write_waitrequest),
        .read_addr        (read_addr),
        .read             (read),
        .oData            (oData),
        .read_waitrequest (read_waitrequest),
        .wr_count         (wr_count),
        .rd_count         (rd_count),
        .addr_err         (addr_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_rd;
        int          cyc;
        logic [31:0] data;
        logic [31:0] wrc;
        logic [31:0] rdc;
        bit          err;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    // Reference model state.
    logic [31:0] mem_m[int];
    logic [31:0] written[$];
    logic [31:0] m_wr = 0;
    logic [31:0] m_rd = 0;
    bit          m_err = 0;
    bit          last_wr_m = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a[31:2] < 30'(FS));
    endfunction

    // Monitor: pop and check on every completion, then check the counters
    // one cycle later, after they have updated.
    initial begin
        exp_t e;
        exp_t post;
        bit   post_pending = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                post_pending = 0;
            end else begin
                if (post_pending) begin
                    check32("wr_count", wr_count, post.wrc);
                    check32("rd_count", rd_count, post.rdc);
                    check32("addr_err", 32'(addr_err), 32'(post.err));
                    post_pending = 0;
                end
                if (!write_waitrequest || !read_waitrequest) begin
                    check32("both_waitrequests_low", 32'(!write_waitrequest && !read_waitrequest), 32'd0);
                    if (exp_q.size() == 0) begin
                        check32("unexpected_completion", {31'd0, read_waitrequest}, {31'd0, write_waitrequest});
                    end else begin
                        e = exp_q.pop_front();
                        check32("completion_type", 32'(!read_waitrequest), 32'(e.is_rd));
                        check32("completion_cycle", 32'(cyc), 32'(e.cyc));
                        if (e.is_rd)
                            check32("read_data", oData, e.data);
                        post = e;
                        post_pending = 1;
                    end
                end
            end
        end
    end

    // Issue a write, a read, or both together. The expected completion order
    // and cycles follow the arbitration and latency rules.
    task automatic do_access(input bit w, input bit r, input logic [31:0] wa,
                             input logic [31:0] d, input logic [31:0] ra);
        int   t;
        int   done;
        bit   first_wr;
        bit   is_wr;
        bit   wpend;
        bit   rpend;
        exp_t e;
        @(negedge clk);
        write = w; read = r; write_addr = wa; iData = d; read_addr = ra;
        t = cyc;
        first_wr = (w && r) ? !last_wr_m : w;
        for (int k = 0; k < ((w && r) ? 2 : 1); k++) begin
            is_wr = (k == 0) ? first_wr : !first_wr;
            e.is_rd = !is_wr;
            e.data  = 32'd0;
            if (is_wr) begin
                done = t + WW + 2;
                if (in_rng(wa)) begin
                    mem_m[int'(wa[31:2])] = d;
                    written.push_back(wa);
                    m_wr++;
                end else begin
                    m_err = 1;
                end
            end else begin
                done = t + RW + 2;
                if (in_rng(ra))
                    e.data = mem_m[int'(ra[31:2])];
                else
                    m_err = 1;
                m_rd++;
            end
            e.cyc = done; e.wrc = m_wr; e.rdc = m_rd; e.err = m_err;
            exp_q.push_back(e);
            last_wr_m = is_wr;
            t = done + 1;
        end
        $display("access w=%0d r=%0d waddr=%h data=%h raddr=%h at cycle %0d", w, r, wa, d, ra, cyc);
        wpend = w; rpend = r;
        for (int i = 0; i < 64 && (wpend || rpend); i++) begin
            @(negedge clk);
            // The address is latched by now, so changing it must have no effect.
            if (!(w && r) && i == 0) begin
                write_addr = $urandom;
                read_addr  = $urandom;
            end
            if (wpend && !write_waitrequest) begin write = 0; wpend = 0; end
            if (rpend && !read_waitrequest)  begin read = 0;  rpend = 0; end
        end
        check32("access_timeout", 32'(wpend || rpend), 32'd0);
        write = 0; read = 0;
    endtask

    // Grant a request, then drop it while it is still waiting. Nothing completes.
    task automatic do_abort(input bit is_wr, input logic [31:0] wa,
                            input logic [31:0] d, input logic [31:0] ra);
        @(negedge clk);
        write = is_wr; read = !is_wr; write_addr = wa; iData = d; read_addr = ra;
        last_wr_m = is_wr;
        $display("abort %s waddr=%h raddr=%h at cycle %0d", is_wr ? "write" : "read", wa, ra, cyc);
        @(negedge clk);
        write = 0; read = 0;
    endtask

    task automatic check_reset_state(input string tag);
        check32({tag, "_wwr"}, 32'(write_waitrequest), 32'd1);
        check32({tag, "_rwr"}, 32'(read_waitrequest), 32'd1);
        check32({tag, "_odata"}, oData, 32'd0);
        check32({tag, "_wrc"}, wr_count, 32'd0);
        check32({tag, "_rdc"}, rd_count, 32'd0);
        check32({tag, "_err"}, 32'(addr_err), 32'd0);
    endtask

    // Assert reset while a write is still waiting. The RAM must keep its old word.
    task automatic do_reset_abort(input logic [31:0] wa, input logic [31:0] d);
        @(negedge clk);
        write = 1; write_addr = wa; iData = d;
        $display("reset during write addr=%h data=%h at cycle %0d", wa, d, cyc);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        check_reset_state("midrst");
        write = 0;
        m_wr = 0; m_rd = 0; m_err = 0; last_wr_m = 0;
        @(negedge clk);
        rst = 0;
    endtask

    function automatic logic [31:0] rand_waddr();
        int r;
        r = $urandom_range(0, 15);
        if (r == 0)
            return 32'($urandom_range(FS, FS + 100)) << 2;
        else if (r == 1)
            return (32'($urandom_range(0, FS - 1)) << 2) | 32'($urandom_range(1, 3));
        else
            return 32'($urandom_range(0, FS - 1)) << 2;
    endfunction

    function automatic logic [31:0] rand_raddr();
        if ($urandom_range(0, 9) == 0 || written.size() == 0)
            return 32'($urandom_range(FS, FS + 100)) << 2;
        return written[$urandom_range(0, written.size() - 1)];
    endfunction

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          sel;
        logic [31:0] wa;
        logic [31:0] ra;
        logic [31:0] d;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 0;

        // Directed cases.
        do_access(1, 0, 32'h10, 32'hCAFEBABE, 32'h0);
        do_access(0, 1, 32'h0, 32'h0, 32'h10);
        do_access(1, 1, 32'h20, 32'h12345678, 32'h10);
        do_access(1, 0, 32'h24, 32'hA5A5A5A5, 32'h0);
        do_access(1, 1, 32'h28, 32'h0BADF00D, 32'h20);
        do_access(1, 0, 32'hA00, 32'h1, 32'h0);
        do_access(0, 1, 32'h0, 32'h0, 32'hA00);
        do_access(1, 0, 32'h9FC, 32'h55AA55AA, 32'h0);
        do_access(0, 1, 32'h0, 32'h0, 32'h9FC);
        do_access(1, 0, 32'h13, 32'h77777777, 32'h0);
        do_abort(1, 32'h10, 32'hDEADBEEF, 32'h0);
        do_access(0, 1, 32'h0, 32'h0, 32'h10);
        do_abort(0, 32'h0, 32'h0, 32'h9FC);
        do_reset_abort(32'h10, 32'h11111111);
        do_access(0, 1, 32'h0, 32'h0, 32'h10);
        do_access(1, 1, 32'h30, 32'hFEEDFACE, 32'h9FC);

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 9);
            wa  = rand_waddr();
            ra  = rand_raddr();
            d   = $urandom;
            if (sel < 4)
                do_access(1, 0, wa, d, 32'h0);
            else if (sel < 7)
                do_access(0, 1, 32'h0, 32'h0, ra);
            else if (sel < 9)
                do_access(1, 1, wa, d, ra);
            else
                do_abort($urandom_range(0, 1) == 1, wa, d, ra);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check32("final_wr_count", wr_count, m_wr);
        check32("final_rd_count", rd_count, m_rd);
        check32("final_addr_err", 32'(addr_err), 32'(m_err));
        check32("pending_expectations", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
